sblk_seq: RTL and testbench
===========================

# sblk_seq

Issue sequencer for one SuperBlock unit column. It accepts a tile descriptor and drives the unit's weight, activation and partial-sum buffer addresses over a two-level loop: K reduction passes × N psum entries. It delays each psum read address by the datapath latency to form the matching write address and write enable. It sits between the layer controller and the `sblk_unit` instances of one column, which share its outputs.

## Interface
- PIPE_LAT, 8: clk_l cycles from an issued pbuf_rd_addr to the cycle its result must be written (pbuf_wr_addr/pbuf_wr_en). Range 1..31.
- CNT_W, 12: width of the N and K loop counters.
- ZERO_ADDR, 0: pbuf address holding all-zero data; used only with SBLK_SEQ_ZINIT_EN.
- clk_l  in  1  low-rate clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  terminate the current tile.
- cfg_n  in  CNT_W  psum entries per pass (N).
- cfg_k  in  CNT_W  reduction passes (K).
- cfg_w_base  in  `WBUF_ADDR_LEN  weight base address.
- cfg_a_base  in  `ACTBUF_ADDR_LEN  activation base address.
- cfg_a_stride  in  `ACTBUF_ADDR_LEN  activation address step per pass.
- cfg_a_inc  in  `ACTBUF_ADDR_LEN  value for actbuf_rd_addr_increment.
- cfg_p_base  in  `PBUF_ADDR_LEN  psum base address.
- wbuf_rd_addr  out  `WBUF_ADDR_LEN  weight read address.
- actbuf_rd_addr  out  `ACTBUF_ADDR_LEN  activation read address.
- actbuf_rd_addr_increment  out  `ACTBUF_ADDR_LEN  latched cfg_a_inc.
- pbuf_rd_addr  out  `PBUF_ADDR_LEN  psum read address.
- pbuf_wr_addr  out  `PBUF_ADDR_LEN  psum write address.
- pbuf_wr_en  out  1  psum write enable.
- busy  out  1  high from RUN through DRAIN.
- done  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. Every output resets to 0.
- States:
  - IDLE: start=1 latches all cfg_* and goes to RUN, or to DONE if cfg_n==0 or cfg_k==0.
  - RUN: issues one slot per cycle.
  - DRAIN: waits for the write pipeline to empty.
  - DONE: pulses done, then returns to IDLE.
- Loop counters: n runs 0..N-1 (inner), k runs 0..K-1 (outer).
- Issue slot (k,n) drives:
  - wbuf_rd_addr = w_base + k·N + n, modulo 2^`WBUF_ADDR_LEN.
  - actbuf_rd_addr = a_base + k·a_stride, modulo 2^`ACTBUF_ADDR_LEN.
  - pbuf_rd_addr = p_base + n, modulo 2^`PBUF_ADDR_LEN.
  - All addresses wrap silently.
- Hazard padding: when N < PIPE_LAT, each pass is padded with PIPE_LAT−N bubble slots. In a bubble, addresses hold their last value and the valid bit is 0. This keeps a pass from reading an entry before the previous pass has written it.
- Write pipeline: a PIPE_LAT-deep shift register carries {valid, pbuf_rd_addr}. Its output drives pbuf_wr_en and pbuf_wr_addr.
- Pass and tile boundaries:
  - After slot (k, N−1), or after the last bubble of a padded pass, n returns to 0 and k increments.
  - After pass K−1 the state moves to DRAIN.
  - DRAIN lasts exactly PIPE_LAT cycles, then DONE.
- abort in RUN or DRAIN: go to DRAIN immediately, stop issuing, and let in-flight writes complete. done still pulses. abort in IDLE is ignored.
- start is ignored unless the state is IDLE. Simultaneous start and abort in IDLE: start wins.
- Reset mid-tile clears the state, the counters and the shift register. No write is emitted after reset.

## Timing
- start sampled at edge 0: busy=1 and the first issue addresses are valid after edge 1.
- Slot issued after edge t: its pbuf_wr_en/pbuf_wr_addr appear after edge t+PIPE_LAT.
- Tile length from start to done: K·max(N,PIPE_LAT) + PIPE_LAT + 1 cycles, after which done=1 for one cycle. busy falls in the same cycle done rises.
- Degenerate tile (N==0 or K==0): done 2 cycles after start, with no write.

## Configuration
- SBLK_SEQ_ZINIT_EN defined: during pass k=0, pbuf_rd_addr = ZERO_ADDR. Write addresses are still p_base+n, so the tile starts from zero psums.
- SBLK_SEQ_ZINIT_EN undefined: pass 0 reads p_base+n and accumulates onto the existing buffer contents.

## Test plan
- Basic tile: N=16, K=2, PIPE_LAT=8, bases w=0x10/a=0x4/p=0x20, a_stride=3.
  - 32 reads; pbuf_rd_addr 0x20..0x2F twice.
  - actbuf_rd_addr 0x4 then 0x7; wbuf 0x10..0x2F.
  - First pbuf_wr_en 8 cycles after the first issue; done at cycle 41.
- Padding: N=3, K=3, PIPE_LAT=8.
  - Each pass is 3 valid + 5 bubble slots.
  - No read of entry n before the previous pass's write to n; done at cycle 33.
- Degenerate: cfg_k=0.
  - done 2 cycles after start; pbuf_wr_en never asserted.
- Abort: abort at the 5th issue of N=16, K=4.
  - Exactly 4 writes still emitted; done PIPE_LAT+1 cycles after abort; start during busy ignored.
- Reset mid-DRAIN: all outputs 0 immediately, no further pbuf_wr_en, and a new start works.
- ZINIT: with SBLK_SEQ_ZINIT_EN, N=4, K=2.
  - Pass 0 reads ZERO_ADDR ×4; pass 1 reads p_base..p_base+3.
  - Without the macro, both passes read p_base+n.

Source files
------------

// File: rtl/sblk_seq.sv
// sblk_seq: issue sequencer for one SuperBlock column, K reduction passes x N psum slots.
// Optional SBLK_SEQ_ZINIT_EN: pass 0 reads ZERO_ADDR so the tile starts from zero psums.
`ifndef WBUF_ADDR_LEN
`define WBUF_ADDR_LEN 10
`endif
`ifndef ACTBUF_ADDR_LEN
`define ACTBUF_ADDR_LEN 10
`endif
`ifndef PBUF_ADDR_LEN
`define PBUF_ADDR_LEN 8
`endif

module sblk_seq #(
  parameter int unsigned PIPE_LAT  = 8,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned ZERO_ADDR = 0
) (
  input  logic                        clk_l,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            cfg_n,
  input  logic [CNT_W-1:0]            cfg_k,
  input  logic [`WBUF_ADDR_LEN-1:0]   cfg_w_base,
  input  logic [`ACTBUF_ADDR_LEN-1:0] cfg_a_base,
  input  logic [`ACTBUF_ADDR_LEN-1:0] cfg_a_stride,
  input  logic [`ACTBUF_ADDR_LEN-1:0] cfg_a_inc,
  input  logic [`PBUF_ADDR_LEN-1:0]   cfg_p_base,
  output logic [`WBUF_ADDR_LEN-1:0]   wbuf_rd_addr,
  output logic [`ACTBUF_ADDR_LEN-1:0] actbuf_rd_addr,
  output logic [`ACTBUF_ADDR_LEN-1:0] actbuf_rd_addr_increment,
  output logic [`PBUF_ADDR_LEN-1:0]   pbuf_rd_addr,
  output logic [`PBUF_ADDR_LEN-1:0]   pbuf_wr_addr,
  output logic                        pbuf_wr_en,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned WW = `WBUF_ADDR_LEN;
  localparam int unsigned AW = `ACTBUF_ADDR_LEN;
  localparam int unsigned PW = `PBUF_ADDR_LEN;
  localparam logic [PW-1:0] ZADDR    = PW'(ZERO_ADDR);
  localparam logic [4:0]    DRN_LAST = 5'(PIPE_LAT - 1);
`ifdef SBLK_SEQ_ZINIT_EN
  localparam bit ZINIT = 1'b1;
`else
  localparam bit ZINIT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  n_q, k_q, n_cfg_q, k_last_q, pass_last_q;
  logic [4:0]        drn_q;
  logic              hold_q;
  logic [WW-1:0]     w_ptr_q, wbuf_q;
  logic [AW-1:0]     a_ptr_q, a_stride_q, act_q, inc_q;
  logic [PW-1:0]     p_base_q, prd_q, pwr_q;
  logic              pwe_q, busy_q, done_q;
  logic              vld_q  [PIPE_LAT];
  logic [PW-1:0]     padr_q [PIPE_LAT];

  logic [CNT_W-1:0]  pass_last_d;
  logic [PW-1:0]     p_wr_d, p_rd_d;

  always_comb begin
    pass_last_d = ((cfg_n > CNT_W'(PIPE_LAT)) ? cfg_n : CNT_W'(PIPE_LAT)) - CNT_W'(1);
    p_wr_d      = p_base_q + PW'(n_q);
    p_rd_d      = (ZINIT && (k_q == '0)) ? ZADDR : p_wr_d;
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      n_cfg_q     <= '0;
      k_last_q    <= '0;
      pass_last_q <= '0;
      drn_q       <= '0;
      hold_q      <= 1'b0;
      w_ptr_q     <= '0;
      wbuf_q      <= '0;
      a_ptr_q     <= '0;
      a_stride_q  <= '0;
      act_q       <= '0;
      inc_q       <= '0;
      p_base_q    <= '0;
      prd_q       <= '0;
      pwr_q       <= '0;
      pwe_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        padr_q[i] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      busy_q   <= (state_q == S_RUN) || (state_q == S_DRAIN);
      vld_q[0] <= 1'b0;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        padr_q[i] <= padr_q[i-1];
      end
      pwe_q <= vld_q[PIPE_LAT-1];
      if (vld_q[PIPE_LAT-1]) pwr_q <= padr_q[PIPE_LAT-1];

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q         <= '0;
            k_q         <= '0;
            n_cfg_q     <= cfg_n;
            k_last_q    <= cfg_k - CNT_W'(1);
            pass_last_q <= pass_last_d;
            w_ptr_q     <= cfg_w_base;
            a_ptr_q     <= cfg_a_base;
            a_stride_q  <= cfg_a_stride;
            inc_q       <= cfg_a_inc;
            p_base_q    <= cfg_p_base;
            // Empty tile waits one extra cycle in DONE so done lands 2 cycles after start.
            if ((cfg_n == '0) || (cfg_k == '0)) begin
              state_q <= S_DONE;
              hold_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_DRAIN;
            drn_q   <= DRN_LAST;
          end else begin
            if (n_q < n_cfg_q) begin
              wbuf_q    <= w_ptr_q;
              w_ptr_q   <= w_ptr_q + WW'(1);
              act_q     <= a_ptr_q;
              prd_q     <= p_rd_d;
              vld_q[0]  <= 1'b1;
              padr_q[0] <= p_wr_d;
            end
            // Slots past N are bubbles: addresses hold, nothing enters the write pipe.
            if (n_q == pass_last_q) begin
              n_q     <= '0;
              k_q     <= k_q + CNT_W'(1);
              a_ptr_q <= a_ptr_q + a_stride_q;
              if (k_q == k_last_q) begin
                state_q <= S_DRAIN;
                drn_q   <= DRN_LAST;
              end
            end else begin
              n_q <= n_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drn_q == '0) state_q <= S_DONE;
          else             drn_q   <= drn_q - 5'd1;
        end
        S_DONE: begin
          if (hold_q) begin
            hold_q <= 1'b0;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbuf_rd_addr             = wbuf_q;
  assign actbuf_rd_addr           = act_q;
  assign actbuf_rd_addr_increment = inc_q;
  assign pbuf_rd_addr             = prd_q;
  assign pbuf_wr_addr             = pwr_q;
  assign pbuf_wr_en               = pwe_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_sblk_seq.sv
// Self-checking bench for sblk_seq: table of tiles plus random tiles against a cycle-indexed model.
`ifndef WBUF_ADDR_LEN
`define WBUF_ADDR_LEN 10
`endif
`ifndef ACTBUF_ADDR_LEN
`define ACTBUF_ADDR_LEN 10
`endif
`ifndef PBUF_ADDR_LEN
`define PBUF_ADDR_LEN 8
`endif

module tb_sblk_seq;

  localparam int P     = 8;
  localparam int CW    = 12;
  localparam int ZA    = 0;
  localparam int WW    = `WBUF_ADDR_LEN;
  localparam int AW    = `ACTBUF_ADDR_LEN;
  localparam int PW    = `PBUF_ADDR_LEN;
  localparam int WMASK = (1 << WW) - 1;
  localparam int AMASK = (1 << AW) - 1;
  localparam int PMASK = (1 << PW) - 1;
`ifdef SBLK_SEQ_ZINIT_EN
  localparam bit ZINIT = 1'b1;
`else
  localparam bit ZINIT = 1'b0;
`endif

  logic          clk_l = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_n = '0, cfg_k = '0;
  logic [WW-1:0] cfg_w_base = '0;
  logic [AW-1:0] cfg_a_base = '0, cfg_a_stride = '0, cfg_a_inc = '0;
  logic [PW-1:0] cfg_p_base = '0;
  logic [WW-1:0] wbuf_rd_addr;
  logic [AW-1:0] actbuf_rd_addr, actbuf_rd_addr_increment;
  logic [PW-1:0] pbuf_rd_addr, pbuf_wr_addr;
  logic          pbuf_wr_en, busy, done;

  sblk_seq #(.PIPE_LAT(P), .CNT_W(CW), .ZERO_ADDR(ZA)) dut (
    .clk_l(clk_l), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base),
    .cfg_a_stride(cfg_a_stride), .cfg_a_inc(cfg_a_inc), .cfg_p_base(cfg_p_base),
    .wbuf_rd_addr(wbuf_rd_addr), .actbuf_rd_addr(actbuf_rd_addr),
    .actbuf_rd_addr_increment(actbuf_rd_addr_increment), .pbuf_rd_addr(pbuf_rd_addr),
    .pbuf_wr_addr(pbuf_wr_addr), .pbuf_wr_en(pbuf_wr_en), .busy(busy), .done(done)
  );

  always #5 clk_l = ~clk_l;

  typedef struct {
    int n, k, wb, ab, as, ai, pb;
    int abort_at;       // edge index (after start) at which abort is sampled; 0 = none
    bit abort_w_start;  // abort driven together with start
    int exp_done;       // hand-derived done cycle, -1 = model only
    int exp_wr;         // hand-derived write count, -1 = model only
  } vec_t;

  int    checks = 0, errors = 0;
  int    cur_cyc = 0;
  string cur_tag = "";
  int    m_w = 0, m_a = 0, m_p = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s cyc=%0d: got 0x%0h expected 0x%0h", cur_tag, nm, cur_cyc, act, exp);
    end
  endfunction

  // Slot issued after edge c of a tile, derived from the loop-nest rules.
  function automatic bit issued(input vec_t v, input int c, output int kk, output int nn);
    int L;
    kk = 0; nn = 0;
    L  = (v.n > P) ? v.n : P;
    if (v.n == 0 || v.k == 0 || c < 1 || c > v.k * L) return 1'b0;
    if (v.abort_at > 0 && c >= v.abort_at) return 1'b0;
    kk = (c - 1) / L;
    nn = (c - 1) % L;
    return nn < v.n;
  endfunction

  task automatic run_tile(input vec_t v, input string tag);
    int  L, done_c, kk, nn, ek, en, wr_cnt, done_seen;
    bit  deg, exp_we;
    cur_tag = tag;
    deg     = (v.n == 0 || v.k == 0);
    L       = (v.n > P) ? v.n : P;
    done_c  = deg ? 2 : ((v.abort_at > 0) ? v.abort_at + P + 1 : v.k * L + P + 1);
    cfg_n = CW'(v.n); cfg_k = CW'(v.k);
    cfg_w_base = WW'(v.wb); cfg_a_base = AW'(v.ab); cfg_a_stride = AW'(v.as);
    cfg_a_inc = AW'(v.ai); cfg_p_base = PW'(v.pb);
    start = 1'b1;
    abort = v.abort_w_start;
    @(posedge clk_l); #1;
    start = 1'b0; abort = 1'b0;
    wr_cnt = 0; done_seen = -1;
    for (int c = 1; c <= done_c + 2; c++) begin
      abort = (c == v.abort_at);
      start = (c == 3 && done_c >= 5);
      @(posedge clk_l); #1;
      abort = 1'b0; start = 1'b0;
      cur_cyc = c;
      if (issued(v, c, kk, nn)) begin
        m_w = (v.wb + kk * v.n + nn) & WMASK;
        m_a = (v.ab + kk * v.as) & AMASK;
        m_p = (ZINIT && kk == 0) ? ZA : ((v.pb + nn) & PMASK);
      end
      exp_we = issued(v, c - P, ek, en);
      check("busy", 32'(busy), 32'(!deg && c < done_c));
      check("done", 32'(done), 32'(c == done_c));
      check("wr_en", 32'(pbuf_wr_en), 32'(exp_we));
      if (exp_we) check("wr_addr", 32'(pbuf_wr_addr), 32'((v.pb + en) & PMASK));
      check("wbuf", 32'(wbuf_rd_addr), 32'(m_w));
      check("act", 32'(actbuf_rd_addr), 32'(m_a));
      check("pbuf_rd", 32'(pbuf_rd_addr), 32'(m_p));
      if (pbuf_wr_en) wr_cnt++;
      if (done) done_seen = c;
    end
    check("inc", 32'(actbuf_rd_addr_increment), 32'(v.ai & AMASK));
    if (v.exp_done >= 0) check("done_cycle", 32'(done_seen), 32'(v.exp_done));
    if (v.exp_wr >= 0)   check("write_count", 32'(wr_cnt), 32'(v.exp_wr));
  endtask

  task automatic check_all_zero(input string tag);
    cur_tag = tag;
    check("outputs_zero", 32'(|{wbuf_rd_addr, actbuf_rd_addr, actbuf_rd_addr_increment,
                                pbuf_rd_addr, pbuf_wr_addr, pbuf_wr_en, busy, done}), 32'(0));
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          n   k   wb     ab     as     ai  pb     abort ab+st done wr
    tbl[0] = '{16, 2, 'h10,  'h4,   3,     1,  'h20,  0, 0, 41, 32};
    tbl[1] = '{3,  3, 'h40,  'h8,   5,     2,  'h30,  0, 0, 33, 9};
    tbl[2] = '{5,  0, 'h11,  'h22,  1,     3,  'h33,  0, 0, 2,  0};
    tbl[3] = '{0,  3, 'h12,  'h23,  1,     4,  'h34,  0, 0, 2,  0};
    tbl[4] = '{16, 4, 'h100, 'h10,  7,     5,  'h40,  5, 0, 14, 4};
    tbl[5] = '{8,  3, 'h20,  'h30,  2,     6,  'h50,  0, 0, 33, 24};
    tbl[6] = '{4,  2, 'h60,  'h70,  9,     7,  'h80,  0, 0, 25, 8};
    tbl[7] = '{1,  1, 'h3,   'h5,   1,     8,  'h7,   0, 0, 17, 1};
    tbl[8] = '{5,  2, 'h3FE, 'h3F0, 'h20,  9,  'hFE,  0, 0, 25, 10};
    tbl[9] = '{2,  2, 'h1,   'h2,   1,     10, 'h3,   0, 1, 25, 4};

    repeat (3) @(posedge clk_l);
    #1 check_all_zero("reset");
    @(negedge clk_l) rst_n = 1'b1;
    @(posedge clk_l); #1;

    foreach (tbl[i]) run_tile(tbl[i], $sformatf("tbl%0d", i));

    // Reset during DRAIN of the basic tile: outputs clear at once, no late writes.
    cur_tag = "rst_drain";
    cfg_n = CW'(16); cfg_k = CW'(2); cfg_w_base = WW'('h10); cfg_a_base = AW'('h4);
    cfg_a_stride = AW'(3); cfg_a_inc = AW'(1); cfg_p_base = PW'('h20);
    start = 1'b1;
    @(posedge clk_l); #1 start = 1'b0;
    repeat (36) @(posedge clk_l);
    #1 check("busy_before_rst", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_drain");
    @(negedge clk_l) rst_n = 1'b1;
    m_w = 0; m_a = 0; m_p = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_l); #1;
      cur_cyc = c;
      check("no_wr_after_rst", 32'(pbuf_wr_en), 32'(0));
      check("no_done_after_rst", 32'(done), 32'(0));
    end
    run_tile(tbl[1], "after_rst");

    for (int t = 0; t < 12; t++) begin
      int L;
      rv.n  = int'($urandom_range(0, 20));
      rv.k  = int'($urandom_range(0, 4));
      rv.wb = int'($urandom_range(0, WMASK));
      rv.ab = int'($urandom_range(0, AMASK));
      rv.as = int'($urandom_range(0, AMASK));
      rv.ai = int'($urandom_range(0, AMASK));
      rv.pb = int'($urandom_range(0, PMASK));
      rv.abort_w_start = ($urandom_range(0, 3) == 0);
      L = (rv.n > P) ? rv.n : P;
      rv.abort_at = (rv.n > 0 && rv.k > 0 && $urandom_range(0, 2) == 0) ?
                    int'($urandom_range(1, rv.k * L)) : 0;
      rv.exp_done = -1;
      rv.exp_wr   = -1;
      run_tile(rv, $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
